// File: rtl/param_stack.sv
// param_stack: parametrised LIFO operand stack with top/next reads, ALU replace-two-with-result and sticky errors
// clock, reset      rising-edge clock, asynchronous active-high reset
// enable            gates push/pop/pop_alu/flush; clear_err is not gated
// data_in           word to push, replace the top with, or ALU result
// data_out/next_out top and second entries, 0 when absent
// count/full/empty  occupancy and status, derived from the count register
// overflow/underflow sticky rejection flags
module param_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             push,
  input  logic             pop,
  input  logic             pop_alu,
  input  logic             flush,
  input  logic             clear_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] next_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt_nxt;
  logic [AW-1:0] wa;
  logic we, ovf_set, unf_set, has1, has2;
  assign full = count == MAX;
  assign empty = count == '0;
  assign has1 = count >= ONE;
  assign has2 = count >= TWO;
  assign data_out = empty ? '0 : mem[AW'(count - ONE)];
  assign next_out = has2 ? mem[AW'(count - TWO)] : '0;
  // pop_alu dominates pop, so pr&p&pa behaves as the ALU result op
  always_comb begin
    we = 1'b0;
    wa = AW'(count);
    cnt_nxt = count;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (enable && flush) cnt_nxt = '0;
    else if (enable && push && pop_alu) begin
      we = has2;
      wa = AW'(count - TWO);
      cnt_nxt = has2 ? count - ONE : count;
      unf_set = !has2;
    end else if (enable && pop_alu) begin
      cnt_nxt = has2 ? count - TWO : count;
      unf_set = !has2;
    end else if (enable && push && pop) begin
      we = has1;
      wa = AW'(count - ONE);
      unf_set = !has1;
    end else if (enable && push) begin
      we = !full;
      cnt_nxt = full ? count : count + ONE;
      ovf_set = full;
    end else if (enable && pop) begin
      cnt_nxt = has1 ? count - ONE : count;
      unf_set = !has1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= cnt_nxt;
      overflow <= ovf_set | (overflow & ~clear_err);
      underflow <= unf_set | (underflow & ~clear_err);
    end
  end
  // storage is never reset; invalid entries are masked on the read side
  always_ff @(posedge clock) begin
    if (we && !reset) mem[wa] <= data_in;
  end
endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;
  logic clock, reset, enable, push, pop, pop_alu, flush, clear_err;
  logic [31:0] data_in, data_out, next_out;
  logic [4:0] count;
  logic full, empty, overflow, underflow;
  int tests = 0;
  int fails = 0;

  param_stack #(.WIDTH(32), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .push(push), .pop(pop),
    .pop_alu(pop_alu), .flush(flush), .clear_err(clear_err), .data_in(data_in),
    .data_out(data_out), .next_out(next_out), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    enable = 0; push = 0; pop = 0; pop_alu = 0; flush = 0; clear_err = 0; data_in = '0;
  endtask

  task automatic op(input logic e, input logic pr, input logic p, input logic pa,
                    input logic fl, input logic ce, input logic [31:0] d);
    enable = e; push = pr; pop = p; pop_alu = pa; flush = fl; clear_err = ce; data_in = d;
    @(posedge clock); #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic fill();
    for (int i = 1; i <= 16; i++) op(1, 1, 0, 0, 0, 0, i);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (data_out !== 32'd0) begin fails++; $display("FAIL reset_data_out got %0h exp 0", data_out); end
    tests++; if (next_out !== 32'd0) begin fails++; $display("FAIL reset_next_out got %0h exp 0", next_out); end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow got %b exp 0", underflow); end
  endtask

  task automatic test_fill();
    do_reset();
    op(1, 1, 0, 0, 0, 0, 32'd1);
    tests++; if (count !== 5'd1 || data_out !== 32'd1 || next_out !== 32'd0 || empty !== 1'b0)
      begin fails++; $display("FAIL push_one got cnt=%0d top=%0d nxt=%0d empty=%b exp 1 1 0 0", count, data_out, next_out, empty); end
    for (int i = 2; i <= 16; i++) op(1, 1, 0, 0, 0, 0, i);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", full); end
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_count got %0d exp 16", count); end
    tests++; if (data_out !== 32'd16) begin fails++; $display("FAIL fill_top got %0d exp 16", data_out); end
    tests++; if (next_out !== 32'd15) begin fails++; $display("FAIL fill_next got %0d exp 15", next_out); end
    op(1, 1, 0, 0, 0, 0, 32'd17);
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL ovf_count got %0d exp 16", count); end
    tests++; if (data_out !== 32'd16) begin fails++; $display("FAIL ovf_top got %0d exp 16", data_out); end
    tests++; if (overflow !== 1'b1 || underflow !== 1'b0)
      begin fails++; $display("FAIL ovf_flags got ovf=%b unf=%b exp 1 0", overflow, underflow); end
    op(1, 0, 1, 0, 0, 0, 32'd0);
    tests++; if (count !== 5'd15 || data_out !== 32'd15 || next_out !== 32'd14 || overflow !== 1'b1)
      begin fails++; $display("FAIL pop_after_full got cnt=%0d top=%0d nxt=%0d ovf=%b exp 15 15 14 1", count, data_out, next_out, overflow); end
    op(0, 0, 0, 0, 0, 1, 32'd0);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL clear_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    op(1, 0, 1, 0, 0, 0, 32'd0);
    tests++; if (underflow !== 1'b1 || count !== 5'd0)
      begin fails++; $display("FAIL pop_empty got unf=%b cnt=%0d exp 1 0", underflow, count); end
    op(0, 0, 0, 0, 0, 1, 32'd0);
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL clear_unf got %b exp 0", underflow); end
    op(1, 1, 0, 0, 0, 0, 32'd5);
    op(1, 0, 0, 1, 0, 0, 32'd0);
    tests++; if (underflow !== 1'b1 || count !== 5'd1 || data_out !== 32'd5)
      begin fails++; $display("FAIL pa_short got unf=%b cnt=%0d top=%0d exp 1 1 5", underflow, count, data_out); end
    op(1, 0, 0, 1, 0, 1, 32'd0);
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL err_beats_clear got %b exp 1", underflow); end
    op(1, 1, 1, 0, 0, 1, 32'd0);
    op(1, 0, 1, 0, 0, 0, 32'd0);
    op(1, 1, 1, 0, 0, 0, 32'd44);
    tests++; if (underflow !== 1'b1 || count !== 5'd0 || data_out !== 32'd0)
      begin fails++; $display("FAIL replace_empty got unf=%b cnt=%0d top=%0d exp 1 0 0", underflow, count, data_out); end
  endtask

  task automatic test_alu();
    do_reset();
    op(1, 1, 0, 0, 0, 0, 32'd7);
    op(1, 1, 0, 0, 0, 0, 32'd3);
    tests++; if (data_out !== 32'd3 || next_out !== 32'd7)
      begin fails++; $display("FAIL two_ops got top=%0d nxt=%0d exp 3 7", data_out, next_out); end
    op(1, 1, 0, 1, 0, 0, 32'd10);
    tests++; if (count !== 5'd1 || data_out !== 32'd10 || next_out !== 32'd0)
      begin fails++; $display("FAIL alu_result got cnt=%0d top=%0d nxt=%0d exp 1 10 0", count, data_out, next_out); end
    op(1, 1, 0, 0, 0, 0, 32'd2);
    op(1, 1, 0, 0, 0, 0, 32'd4);
    op(1, 1, 1, 1, 0, 0, 32'd9);
    tests++; if (count !== 5'd2 || data_out !== 32'd9 || next_out !== 32'd10 || underflow !== 1'b0)
      begin fails++; $display("FAIL alu_pop_ignored got cnt=%0d top=%0d nxt=%0d unf=%b exp 2 9 10 0", count, data_out, next_out, underflow); end
    op(1, 0, 1, 1, 0, 0, 32'd0);
    tests++; if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0)
      begin fails++; $display("FAIL pa_two got cnt=%0d empty=%b unf=%b exp 0 1 0", count, empty, underflow); end
  endtask

  task automatic test_replace();
    do_reset();
    fill();
    op(1, 1, 1, 0, 0, 0, 32'hAA);
    tests++; if (count !== 5'd16 || data_out !== 32'hAA || next_out !== 32'd15)
      begin fails++; $display("FAIL replace_full got cnt=%0d top=%0h nxt=%0d exp 16 aa 15", count, data_out, next_out); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL replace_no_ovf got %b exp 0", overflow); end
    op(0, 1, 0, 0, 0, 0, 32'h55);
    tests++; if (count !== 5'd16 || data_out !== 32'hAA || overflow !== 1'b0)
      begin fails++; $display("FAIL disabled_push got cnt=%0d top=%0h ovf=%b exp 16 aa 0", count, data_out, overflow); end
    op(0, 0, 1, 0, 1, 0, 32'd0);
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL disabled_pop_flush got %0d exp 16", count); end
  endtask

  task automatic test_flush();
    do_reset();
    op(1, 1, 0, 0, 0, 0, 32'd1);
    op(1, 1, 0, 0, 0, 0, 32'd2);
    op(1, 1, 0, 0, 0, 0, 32'd3);
    op(1, 1, 0, 0, 1, 0, 32'd4);
    tests++; if (count !== 5'd0 || empty !== 1'b1 || data_out !== 32'd0)
      begin fails++; $display("FAIL flush got cnt=%0d empty=%b top=%0d exp 0 1 0", count, empty, data_out); end
    op(1, 0, 1, 0, 0, 0, 32'd0);
    op(1, 0, 0, 0, 1, 0, 32'd0);
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL flush_keeps_err got %b exp 1", underflow); end
    op(1, 0, 0, 0, 1, 1, 32'd0);
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL flush_clear got %b exp 0", underflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    op(1, 1, 0, 0, 0, 0, 32'd11);
    op(1, 1, 0, 0, 0, 0, 32'd22);
    op(1, 0, 1, 0, 0, 0, 32'd0);
    op(1, 1, 0, 0, 0, 0, 32'd33);
    tests++; if (count !== 5'd2 || data_out !== 32'd33 || next_out !== 32'd11)
      begin fails++; $display("FAIL b2b got cnt=%0d top=%0d nxt=%0d exp 2 33 11", count, data_out, next_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    op(1, 1, 0, 0, 0, 0, 32'd8);
    op(1, 0, 1, 0, 0, 0, 32'd0);
    op(1, 0, 1, 0, 0, 0, 32'd0);
    op(1, 1, 0, 0, 0, 0, 32'd6);
    enable = 1; push = 1; data_in = 32'd9;
    #2 reset = 1;
    #1;
    tests++; if (count !== 5'd0 || empty !== 1'b1 || data_out !== 32'd0 || underflow !== 1'b0)
      begin fails++; $display("FAIL async_reset got cnt=%0d empty=%b top=%0d unf=%b exp 0 1 0 0", count, empty, data_out, underflow); end
    @(posedge clock); #1;
    idle();
    reset = 0;
    @(posedge clock); #1;
    tests++; if (count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0)
      begin fails++; $display("FAIL after_release got cnt=%0d ovf=%b unf=%b exp 0 0 0", count, overflow, underflow); end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_fill();
    test_underflow();
    test_alu();
    test_replace();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
